// File: rtl/universal_register_n_pkg.sv
// Shared definitions for the universal shift/rotate/load register:
// operation encoding, width limits and the carry-out selection helper.
package reg_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'b000,
        LOAD  = 3'b001,
        SHL   = 3'b010,
        SHR   = 3'b011,
        ROL   = 3'b100,
        ROR   = 3'b101,
        ASR   = 3'b110,
        CLEAR = 3'b111
    } mode_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    // Bit leaving the register for the given operation; modes that move no
    // bit out keep the previous carry, CLEAR forces it low.
    function automatic logic next_cout(
        input mode_t mode,
        input logic  msb,
        input logic  lsb,
        input logic  cout
    );
        logic result;
        case (mode)
            SHL, ROL:      result = msb;
            SHR, ROR, ASR: result = lsb;
            CLEAR:         result = 1'b0;
            HOLD, LOAD:    result = cout;
            default:       result = cout;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/universal_reg_slice.sv
// One bit of the universal register: next-value selection from the
// neighbouring bits plus an enabled flop with asynchronous reset.
module universal_reg_slice
    import reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_t mode,
    input  logic  d,
    input  logic  lo_shift,
    input  logic  lo_rot,
    input  logic  hi_shift,
    input  logic  hi_rot,
    input  logic  hi_arith,
    output logic  q
);

    logic next;

    // Next-value mux: left moves pull from the lower neighbour, right moves
    // from the upper one; the edge bits receive serial or wrapped inputs.
    always_comb begin
        next = q;
        case (mode)
            HOLD:    next = q;
            LOAD:    next = d;
            SHL:     next = lo_shift;
            SHR:     next = hi_shift;
            ROL:     next = lo_rot;
            ROR:     next = hi_rot;
            ASR:     next = hi_arith;
            CLEAR:   next = 1'b0;
            default: next = q;
        endcase
    end

    // Storage flop: reset wins over everything, enable gates all updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= next;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/universal_register_n.sv
// WIDTH-bit universal register: hold, load, logical shifts, rotates,
// arithmetic right shift and clear, with registered carry-out and zero flag.
module universal_register_n
    import reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_r,
    input  logic             i_sin_l,
    output logic [WIDTH-1:0] o_q,
    output logic             o_cout,
    output logic             o_zero
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("universal_register_n: WIDTH must be in 2..64");
    end

    mode_t            mode;
    logic [WIDTH-1:0] q;
    logic             cout;

    assign mode = mode_t'(i_mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic lo_shift;
        logic lo_rot;
        logic hi_shift;
        logic hi_rot;
        logic hi_arith;

        // Bit 0 takes the right serial input on SHL and the MSB on ROL.
        if (i == 0) begin : g_lsb
            assign lo_shift = i_sin_r;
            assign lo_rot   = q[WIDTH-1];
        end else begin : g_lo
            assign lo_shift = q[i-1];
            assign lo_rot   = q[i-1];
        end

        // The MSB takes the left serial input on SHR, the LSB on ROR and
        // keeps its own value on ASR so the sign is replicated.
        if (i == WIDTH - 1) begin : g_msb
            assign hi_shift = i_sin_l;
            assign hi_rot   = q[0];
            assign hi_arith = q[WIDTH-1];
        end else begin : g_hi
            assign hi_shift = q[i+1];
            assign hi_rot   = q[i+1];
            assign hi_arith = q[i+1];
        end

        universal_reg_slice #(
            .RESET_BIT (RESET_VAL[i])
        ) u_slice (
            .clk      (i_clk),
            .rst      (i_rst),
            .en       (i_en),
            .mode     (mode),
            .d        (i_d[i]),
            .lo_shift (lo_shift),
            .lo_rot   (lo_rot),
            .hi_shift (hi_shift),
            .hi_rot   (hi_rot),
            .hi_arith (hi_arith),
            .q        (q[i])
        );
    end

    // Carry-out flop, kept outside the bit slices since it depends on the
    // register's edge bits and its own previous value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cout <= 1'b0;
        end else if (i_en) begin
            cout <= next_cout(mode, q[WIDTH-1], q[0], cout);
        end else begin
            cout <= cout;
        end
    end

    assign o_q    = q;
    assign o_cout = cout;
    assign o_zero = (q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register_n.sv
// Randomised scoreboard bench for universal_register_n: two instances
// (reset value 0x00 and 0x3C) are compared against an arithmetic model.
module tb_universal_register_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q_a, q_b;
    logic       cout_a, cout_b, zero_a, zero_b;

    universal_register_n #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_sin_r(sin_r), .i_sin_l(sin_l),
        .o_q(q_a), .o_cout(cout_a), .o_zero(zero_a)
    );

    universal_register_n #(.WIDTH(8), .RESET_VAL(8'h3C)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_sin_r(sin_r), .i_sin_l(sin_l),
        .o_q(q_b), .o_cout(cout_b), .o_zero(zero_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] qa;
        logic       ca;
        logic [7:0] qb;
        logic       cb;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: index 0 is the 0x00-reset instance, 1 the 0x3C one.
    int   mq[2];
    int   mc[2];
    int   rv[2] = '{8'h00, 8'h3C};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%02h required=%02h at %0t", name, act, req, $time);
        end
    endtask

    // Operation semantics expressed as integer arithmetic on an 8-bit value.
    task automatic model_step(input int m, input int dd, input int sr, input int sl,
                              inout int v, inout int c);
        case (m)
            1: v = dd;
            2: begin c = (v >> 7) & 1; v = ((v * 2) + sr) % 256; end
            3: begin c = v % 2; v = (v / 2) + sl * 128; end
            4: begin c = (v >> 7) & 1; v = ((v * 2) % 256) + (v / 128); end
            5: begin c = v % 2; v = (v / 2) + (v % 2) * 128; end
            6: begin c = v % 2; v = (v / 2) + (v / 128) * 128; end
            7: begin v = 0; c = 0; end
            default: ;
        endcase
    endtask

    task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic sr, input logic sl, input bit release_rst,
                         input string tag);
        exp_t x;
        @(negedge clk);
        en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        if (e) begin
            for (int k = 0; k < 2; k++) model_step(int'(m), int'(dd), int'(sr), int'(sl), mq[k], mc[k]);
        end
        x.qa = mq[0][7:0]; x.ca = mc[0][0];
        x.qb = mq[1][7:0]; x.cb = mc[1][0];
        x.tag = tag;
        sb.push_back(x);
        if (release_rst) begin
            #2 rst = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_q_a"}, q_a, 8'h00);
        chk({tag, "_cout_a"}, {7'd0, cout_a}, 8'h00);
        chk({tag, "_zero_a"}, {7'd0, zero_a}, 8'h01);
        chk({tag, "_q_b"}, q_b, 8'h3C);
        chk({tag, "_cout_b"}, {7'd0, cout_b}, 8'h00);
        chk({tag, "_zero_b"}, {7'd0, zero_b}, 8'h00);
    endtask

    // Assert reset between edges, check it acts at once and holds over edges.
    task automatic mid_reset(input int hold_edges, input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 2; k++) begin mq[k] = rv[k]; mc[k] = 0; end
        #1 check_reset_state({tag, "_async"});
        for (int k = 0; k < hold_edges; k++) begin
            @(posedge clk); #1;
            check_reset_state({tag, "_held"});
        end
    endtask

    // Monitor: one expectation is consumed per active edge after stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk({x.tag, "_q_a"}, q_a, x.qa);
                chk({x.tag, "_cout_a"}, {7'd0, cout_a}, {7'd0, x.ca});
                chk({x.tag, "_zero_a"}, {7'd0, zero_a}, {7'd0, (x.qa == 8'h00)});
                chk({x.tag, "_q_b"}, q_b, x.qb);
                chk({x.tag, "_cout_b"}, {7'd0, cout_b}, {7'd0, x.cb});
                chk({x.tag, "_zero_b"}, {7'd0, zero_b}, {7'd0, (x.qb == 8'h00)});
            end
        end
    end

    initial begin
        logic [2:0] rm;
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        for (int k = 0; k < 2; k++) begin mq[k] = rv[k]; mc[k] = 0; end
        #2 check_reset_state("por");

        apply(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b1, "load_a5");
        for (int k = 0; k < 3; k++) apply(1'b0, 3'd1, 8'hFF, 1'b1, 1'b1, 1'b0, "en_low_hold");
        apply(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, "shl_sin1");
        apply(1'b1, 3'd3, 8'hFF, 1'b1, 1'b0, 1'b0, "shr_sin0");
        apply(1'b1, 3'd0, 8'h5A, 1'b1, 1'b1, 1'b0, "hold_mode");
        apply(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, "load_81");
        apply(1'b1, 3'd5, 8'h00, 1'b1, 1'b1, 1'b0, "ror_81");
        apply(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, "load_81b");
        for (int k = 0; k < 8; k++) apply(1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 1'b0, "rol_wrap");
        for (int k = 0; k < 8; k++) apply(1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0, "ror_wrap");
        apply(1'b1, 3'd1, 8'h80, 1'b0, 1'b0, 1'b0, "load_80");
        apply(1'b1, 3'd6, 8'h00, 1'b1, 1'b1, 1'b0, "asr_80");
        apply(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b0, "clear");
        apply(1'b1, 3'd1, 8'h0F, 1'b0, 1'b0, 1'b0, "load_0f");
        apply(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, "shl_seq");
        apply(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, "shl_seq");
        mid_reset(2, "mid_rst");
        apply(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1, "shl_after_rst");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                mid_reset($urandom_range(0, 2), "rand_rst");
                rm = 3'($urandom_range(0, 7));
                apply(1'b1, rm, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, "rand_release");
            end else begin
                rm = 3'($urandom_range(0, 7));
                apply(($urandom_range(0, 3) != 0), rm, 8'($urandom),
                      1'($urandom), 1'($urandom), 1'b0, "rand_op");
            end
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/universal_register_n.md
UNIVERSAL_REGISTER_N -- requirements
Module: universal_register_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default '0 (WIDTH bits), value loaded into o_q on reset.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_en  input  1  operation enable; low means all state holds.
REQ-006 i_mode  input  3  operation select (mode_t, see Function).
REQ-007 i_d  input  WIDTH  parallel load data.
REQ-008 i_sin_r  input  1  serial input entering at bit 0 on SHL.
REQ-009 i_sin_l  input  1  serial input entering at bit WIDTH-1 on SHR.
REQ-010 o_q  output  WIDTH  registered contents.
REQ-011 o_cout  output  1  registered copy of the last bit shifted or rotated out.
REQ-012 o_zero  output  1  combinational flag, high when o_q equals 0.

Function
REQ-013 State (o_q, o_cout) SHALL update only on rising i_clk when i_en=1 and i_rst=0; one-cycle latency from inputs to o_q/o_cout.
REQ-014 With i_en=0, o_q and o_cout SHALL hold regardless of i_mode, i_d and the serial inputs.
REQ-015 HOLD (3'b000): o_q and o_cout unchanged.
REQ-016 LOAD (3'b001): o_q <= i_d; o_cout unchanged.
REQ-017 SHL (3'b010): o_q <= {o_q[W-2:0], i_sin_r}; o_cout <= o_q[W-1].
REQ-018 SHR (3'b011): o_q <= {i_sin_l, o_q[W-1:1]}; o_cout <= o_q[0].
REQ-019 ROL (3'b100): o_q <= {o_q[W-2:0], o_q[W-1]}; o_cout <= o_q[W-1].
REQ-020 ROR (3'b101): o_q <= {o_q[0], o_q[W-1:1]}; o_cout <= o_q[0].
REQ-021 ASR (3'b110): o_q <= {o_q[W-1], o_q[W-1:1]}; o_cout <= o_q[0]; serial inputs ignored.
REQ-022 CLEAR (3'b111): o_q <= 0 (not RESET_VAL); o_cout <= 0.
REQ-023 Serial inputs SHALL be ignored in every mode except SHL (i_sin_r) and SHR (i_sin_l).
REQ-024 o_zero SHALL track o_q combinationally with no added register stage.
REQ-025 Repeated ROL or ROR SHALL wrap: WIDTH consecutive rotations return o_q to its starting value.

Reset
REQ-026 i_rst=1 SHALL force o_q=RESET_VAL and o_cout=0 immediately, independent of i_clk and i_en.
REQ-027 o_zero during reset SHALL equal (RESET_VAL==0).
REQ-028 Reset asserted mid-sequence SHALL abort the sequence; no operation SHALL be remembered across reset.
REQ-029 The first rising edge with i_rst=0 after deassertion SHALL perform the selected operation normally.

Structure
REQ-030 Shared package reg_pkg SHALL hold typedef enum logic [2:0] mode_t {HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLEAR} with the encodings above.
REQ-031 Sub-module universal_reg_slice (one bit: next-value mux plus async-reset enabled flip-flop) SHALL be instantiated WIDTH times via generate; o_cout SHALL be a separate flop in the top level.
REQ-032 An elaboration-time check SHALL reject WIDTH < 2.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-033 Assert i_rst between clock edges -> o_q=0x00, o_cout=0, o_zero=1 before the next edge; with RESET_VAL=0x3C -> o_q=0x3C, o_zero=0.
REQ-034 LOAD i_d=0xA5, i_en=1 -> o_q=0xA5 after one edge; then i_en=0, LOAD i_d=0xFF -> o_q stays 0xA5 for 3 edges.
REQ-035 From 0xA5: SHL, i_sin_r=1 -> o_q=0x4B, o_cout=1; then SHR, i_sin_l=0 -> o_q=0x25, o_cout=1.
REQ-036 From 0x81: ROR once -> o_q=0xC0, o_cout=1; from 0x81, ROL 8 times -> o_q=0x81.
REQ-037 From 0x80: ASR -> o_q=0xC0, o_cout=0; then CLEAR -> o_q=0x00, o_cout=0, o_zero=1.
REQ-038 Assert i_rst during a SHL sequence, release between edges -> o_q=0x00 held until release; first edge after release applies SHL with i_sin_r=1 -> o_q=0x01.
